// File: rtl/tap_pkg.sv
// -----------------------------------------------------------------------------
// tap_pkg
// Shared definitions for the IEEE 1149.1 TAP controller.
//   STATE_W        width of the encoded TAP state (fixed at 4)
//   tap_state_t    the 16 TAP states, encoded per the 1149.1 hex table
//   is_ir_column() true for SelIR through UpdIR
//   next_state()   TMS-driven transition function
// -----------------------------------------------------------------------------
package tap_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    EX2_DR   = 4'h0,
    EX1_DR   = 4'h1,
    SH_DR    = 4'h2,
    PAUSE_DR = 4'h3,
    SEL_IR   = 4'h4,
    UPD_DR   = 4'h5,
    CAP_DR   = 4'h6,
    SEL_DR   = 4'h7,
    EX2_IR   = 4'h8,
    EX1_IR   = 4'h9,
    SH_IR    = 4'hA,
    PAUSE_IR = 4'hB,
    RTI      = 4'hC,
    UPD_IR   = 4'hD,
    CAP_IR   = 4'hE,
    TLR      = 4'hF
  } tap_state_t;

  function automatic logic is_ir_column(tap_state_t s);
    case (s)
      SEL_IR, CAP_IR, SH_IR, EX1_IR, PAUSE_IR, EX2_IR, UPD_IR: is_ir_column = 1'b1;
      default:                                                 is_ir_column = 1'b0;
    endcase
  endfunction

  function automatic tap_state_t next_state(tap_state_t s, logic tms);
    case (s)
      TLR:      next_state = tms ? TLR      : RTI;
      RTI:      next_state = tms ? SEL_DR   : RTI;
      SEL_DR:   next_state = tms ? SEL_IR   : CAP_DR;
      CAP_DR:   next_state = tms ? EX1_DR   : SH_DR;
      SH_DR:    next_state = tms ? EX1_DR   : SH_DR;
      EX1_DR:   next_state = tms ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: next_state = tms ? EX2_DR   : PAUSE_DR;
      EX2_DR:   next_state = tms ? UPD_DR   : SH_DR;
      UPD_DR:   next_state = tms ? SEL_DR   : RTI;
      SEL_IR:   next_state = tms ? TLR      : CAP_IR;
      CAP_IR:   next_state = tms ? EX1_IR   : SH_IR;
      SH_IR:    next_state = tms ? EX1_IR   : SH_IR;
      EX1_IR:   next_state = tms ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: next_state = tms ? EX2_IR   : PAUSE_IR;
      EX2_IR:   next_state = tms ? UPD_IR   : SH_IR;
      UPD_IR:   next_state = tms ? SEL_DR   : RTI;
      default:  next_state = TLR;
    endcase
  endfunction

endpackage

// File: rtl/tap_if.sv
// -----------------------------------------------------------------------------
// tap_if
// Bundle between the TAP controller and the scan registers it drives.
//   TMS             test mode select, into the controller
//   TapState        current encoded state (debug)
//   TestLogicReset, CaptureDR, ShiftDR, ShiftIR   Moore state decodes
//   ClockDR, ClockIR, UpdateDR, UpdateIR          gated TCK, idle high
//   Select          1 = IR path, 0 = DR path (TDO mux)
//   Enable          TDO output enable
// Transfer semantics: there is no valid/ready handshake. TMS is level-sampled
// on every rising TCK, and every TCK cycle is one state step; the registers on
// the slave side act on the gated clocks and decodes without back-pressure.
// -----------------------------------------------------------------------------
interface tap_if;
  import tap_pkg::*;

  logic               TMS;
  logic [STATE_W-1:0] TapState;
  logic               TestLogicReset;
  logic               CaptureDR;
  logic               ShiftDR;
  logic               ClockDR;
  logic               UpdateDR;
  logic               ShiftIR;
  logic               ClockIR;
  logic               UpdateIR;
  logic               Select;
  logic               Enable;

  modport master (
    input  TMS,
    output TapState, TestLogicReset, CaptureDR, ShiftDR, ClockDR, UpdateDR,
           ShiftIR, ClockIR, UpdateIR, Select, Enable
  );

  modport slave (
    output TMS,
    input  TapState, TestLogicReset, CaptureDR, ShiftDR, ClockDR, UpdateDR,
           ShiftIR, ClockIR, UpdateIR, Select, Enable
  );
endinterface

// File: rtl/tap_clock_gate.sv
// -----------------------------------------------------------------------------
// tap_clock_gate
// Gated copy of TCK: gclk = clk | ~enable, where enable is registered on the
// falling clk edge. While clk is high the output is always high; during the
// low half-cycle it is low only if the enable was set at that falling edge,
// so the output rises exactly at the rising clk that ends an enabled cycle.
//   clk   TCK
//   en    enable for the cycle now in progress (sampled on falling clk)
//   gclk  gated clock, idle high
// -----------------------------------------------------------------------------
module tap_clock_gate (
  input  logic clk,
  input  logic en,
  output wire  gclk
);

  // Holds the inverted enable so the gate itself is a single OR cell.
  logic en_n_q;

  always_ff @(negedge clk) begin
    en_n_q <= ~en;
  end

  or u_or (gclk, clk, en_n_q);

endmodule

// File: rtl/tap_controller.sv
// -----------------------------------------------------------------------------
// tap_controller
// IEEE 1149.1 TAP state machine driving the bypass, instruction and
// boundary-scan registers of the ripple-adder DFT chain.
//   TCK    test clock (rising edge: state, falling edge: enables)
//   Reset  synchronous active-high, forces Test-Logic-Reset
//   bus    tap_if.master: TMS in; state, decodes, gated clocks, Select/Enable out
// -----------------------------------------------------------------------------
module tap_controller
  import tap_pkg::*;
(
  input logic   TCK,
  input logic   Reset,
  tap_if.master bus
);

  tap_state_t state;
  tap_state_t state_nxt;

  logic test_logic_reset;
  logic capture_dr;
  logic shift_dr;
  logic shift_ir;
  logic dr_clk_en;
  logic ir_clk_en;
  logic dr_upd_en;
  logic ir_upd_en;
  logic enable_d;
  logic select_d;
  logic enable_q;
  logic select_q;

  // State register; Reset overrides TMS in every state.
  always_ff @(posedge TCK) begin
    if (Reset) begin
      state <= TLR;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state plus all decodes of the current state.
  always_comb begin
    state_nxt        = state;
    test_logic_reset = 1'b0;
    capture_dr       = 1'b0;
    shift_dr         = 1'b0;
    shift_ir         = 1'b0;
    dr_clk_en        = 1'b0;
    ir_clk_en        = 1'b0;
    dr_upd_en        = 1'b0;
    ir_upd_en        = 1'b0;
    enable_d         = 1'b0;
    select_d         = 1'b0;

    state_nxt        = next_state(state, bus.TMS);
    test_logic_reset = (state == TLR);
    capture_dr       = (state == CAP_DR);
    shift_dr         = (state == SH_DR);
    shift_ir         = (state == SH_IR);
    dr_clk_en        = (state == CAP_DR) || (state == SH_DR);
    ir_clk_en        = (state == CAP_IR) || (state == SH_IR);
    dr_upd_en        = (state == UPD_DR);
    ir_upd_en        = (state == UPD_IR);
    enable_d         = (state == SH_DR) || (state == SH_IR);
    select_d         = is_ir_column(state);
  end

  // TDO-path controls change on falling TCK so they are stable around the
  // rising edge at which downstream registers shift. In TLR both clear.
  always_ff @(negedge TCK) begin
    enable_q <= enable_d;
    select_q <= select_d;
  end

  tap_clock_gate u_clock_dr  (.clk(TCK), .en(dr_clk_en), .gclk(bus.ClockDR));
  tap_clock_gate u_clock_ir  (.clk(TCK), .en(ir_clk_en), .gclk(bus.ClockIR));
  tap_clock_gate u_update_dr (.clk(TCK), .en(dr_upd_en), .gclk(bus.UpdateDR));
  tap_clock_gate u_update_ir (.clk(TCK), .en(ir_upd_en), .gclk(bus.UpdateIR));

  assign bus.TapState       = state;
  assign bus.TestLogicReset = test_logic_reset;
  assign bus.CaptureDR      = capture_dr;
  assign bus.ShiftDR        = shift_dr;
  assign bus.ShiftIR        = shift_ir;
  assign bus.Enable         = enable_q;
  assign bus.Select         = select_q;

endmodule

// File: tb/tb_tap_controller.sv
// -----------------------------------------------------------------------------
// tb_tap_controller
// Self-checking bench for tap_controller: table-driven state model with a
// per-edge compare process, directed walks with literal expectations, and a
// randomized TMS/Reset phase.
// -----------------------------------------------------------------------------
module tb_tap_controller;

  localparam logic [3:0] S_EX2DR = 4'h0, S_EX1DR = 4'h1, S_SHDR = 4'h2, S_PAUSEDR = 4'h3;
  localparam logic [3:0] S_SELIR = 4'h4, S_UPDDR = 4'h5, S_CAPDR = 4'h6, S_SELDR = 4'h7;
  localparam logic [3:0] S_EX2IR = 4'h8, S_EX1IR = 4'h9, S_SHIR = 4'hA, S_PAUSEIR = 4'hB;
  localparam logic [3:0] S_RTI = 4'hC, S_UPDIR = 4'hD, S_CAPIR = 4'hE, S_TLR = 4'hF;

  // ---------------- clock / reset ----------------
  logic tck = 1'b0;
  logic rst = 1'b1;
  logic tdi = 1'b0;
  always #5 tck = ~tck;

  tap_if bus_if ();

  tap_controller dut (
    .TCK  (tck),
    .Reset(rst),
    .bus  (bus_if)
  );

  // ---------------- scoreboard state ----------------
  int checks   = 0;
  int failures = 0;
  logic [0:0] exp_q[$];

  logic [3:0] nx0[16];
  logic [3:0] nx1[16];

  logic [3:0] m_state = S_TLR;
  bit m_valid  = 1'b0;
  bit m_fvalid = 1'b0;
  bit m_dr_en, m_ir_en, m_dr_upd, m_ir_upd, m_enable, m_select;

  // Low-half-cycle samples; a gated clock that was low there rises at the
  // next rising TCK.
  logic lo_clkdr = 1'b1, lo_clkir = 1'b1, lo_upddr = 1'b1, lo_updir = 1'b1;
  logic lo_shdr = 1'b0, lo_tdi = 1'b0;
  int n_clkdr = 0, n_clkir = 0, n_upddr = 0, n_updir = 0;
  logic tdo = 1'b0;  // bypass register fed by D = TDI & ShiftDR on ClockDR

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process ----------------
  always @(posedge tck) begin
    if (m_fvalid) begin
      if (!lo_clkdr) begin
        n_clkdr++;
        tdo = lo_tdi & lo_shdr;
      end
      if (!lo_clkir) n_clkir++;
      if (!lo_upddr) n_upddr++;
      if (!lo_updir) n_updir++;
    end
    if (rst) begin
      m_state = S_TLR;
      m_valid = 1'b1;
    end else if (m_valid) begin
      m_state = bus_if.TMS ? nx1[m_state] : nx0[m_state];
    end
    #1;
    if (m_valid) begin
      check("tap_state", bus_if.TapState, m_state);
      check("test_logic_reset", bus_if.TestLogicReset, m_state == S_TLR);
      check("capture_dr", bus_if.CaptureDR, m_state == S_CAPDR);
      check("shift_dr", bus_if.ShiftDR, m_state == S_SHDR);
      check("shift_ir", bus_if.ShiftIR, m_state == S_SHIR);
    end
    if (m_fvalid) begin
      check("clock_dr_high", bus_if.ClockDR, 1);
      check("clock_ir_high", bus_if.ClockIR, 1);
      check("update_dr_high", bus_if.UpdateDR, 1);
      check("update_ir_high", bus_if.UpdateIR, 1);
    end
  end

  always @(negedge tck) begin
    if (m_valid) begin
      m_dr_en  = m_state inside {S_CAPDR, S_SHDR};
      m_ir_en  = m_state inside {S_CAPIR, S_SHIR};
      m_dr_upd = (m_state == S_UPDDR);
      m_ir_upd = (m_state == S_UPDIR);
      m_enable = m_state inside {S_SHDR, S_SHIR};
      m_select = m_state inside {S_SELIR, S_CAPIR, S_SHIR, S_EX1IR, S_PAUSEIR, S_EX2IR, S_UPDIR};
      m_fvalid = 1'b1;
    end
    #1;
    if (m_fvalid) begin
      check("select", bus_if.Select, m_select);
      check("enable", bus_if.Enable, m_enable);
      check("clock_dr_low", bus_if.ClockDR, !m_dr_en);
      check("clock_ir_low", bus_if.ClockIR, !m_ir_en);
      check("update_dr_low", bus_if.UpdateDR, !m_dr_upd);
      check("update_ir_low", bus_if.UpdateIR, !m_ir_upd);
      lo_clkdr = bus_if.ClockDR;
      lo_clkir = bus_if.ClockIR;
      lo_upddr = bus_if.UpdateDR;
      lo_updir = bus_if.UpdateIR;
      lo_shdr  = bus_if.ShiftDR;
      lo_tdi   = tdi;
    end
  end

  // ---------------- driver tasks ----------------
  // Inputs change 2 time units after an edge, well away from rising TCK.
  task automatic step(input bit tms, input bit r);
    bus_if.TMS = tms;
    rst = r;
    @(posedge tck);
    #2;
  endtask

  task automatic to_low_half();
    @(negedge tck);
    #2;
  endtask

  task automatic tms_ones(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  string      paths[16];
  logic [3:0] targ[16];
  logic [7:0] pat;
  int         base_dr, base_ir, base_udr, base_uir;
  logic [3:0] walk_states[7];
  logic       walk_sel[7];

  initial begin
    nx0[S_TLR]     = S_RTI;     nx1[S_TLR]     = S_TLR;
    nx0[S_RTI]     = S_RTI;     nx1[S_RTI]     = S_SELDR;
    nx0[S_SELDR]   = S_CAPDR;   nx1[S_SELDR]   = S_SELIR;
    nx0[S_CAPDR]   = S_SHDR;    nx1[S_CAPDR]   = S_EX1DR;
    nx0[S_SHDR]    = S_SHDR;    nx1[S_SHDR]    = S_EX1DR;
    nx0[S_EX1DR]   = S_PAUSEDR; nx1[S_EX1DR]   = S_UPDDR;
    nx0[S_PAUSEDR] = S_PAUSEDR; nx1[S_PAUSEDR] = S_EX2DR;
    nx0[S_EX2DR]   = S_SHDR;    nx1[S_EX2DR]   = S_UPDDR;
    nx0[S_UPDDR]   = S_RTI;     nx1[S_UPDDR]   = S_SELDR;
    nx0[S_SELIR]   = S_CAPIR;   nx1[S_SELIR]   = S_TLR;
    nx0[S_CAPIR]   = S_SHIR;    nx1[S_CAPIR]   = S_EX1IR;
    nx0[S_SHIR]    = S_SHIR;    nx1[S_SHIR]    = S_EX1IR;
    nx0[S_EX1IR]   = S_PAUSEIR; nx1[S_EX1IR]   = S_UPDIR;
    nx0[S_PAUSEIR] = S_PAUSEIR; nx1[S_PAUSEIR] = S_EX2IR;
    nx0[S_EX2IR]   = S_SHIR;    nx1[S_EX2IR]   = S_UPDIR;
    nx0[S_UPDIR]   = S_RTI;     nx1[S_UPDIR]   = S_SELDR;

    paths[0]  = "";        targ[0]  = S_TLR;
    paths[1]  = "0";       targ[1]  = S_RTI;
    paths[2]  = "01";      targ[2]  = S_SELDR;
    paths[3]  = "010";     targ[3]  = S_CAPDR;
    paths[4]  = "0100";    targ[4]  = S_SHDR;
    paths[5]  = "0101";    targ[5]  = S_EX1DR;
    paths[6]  = "01010";   targ[6]  = S_PAUSEDR;
    paths[7]  = "010101";  targ[7]  = S_EX2DR;
    paths[8]  = "01011";   targ[8]  = S_UPDDR;
    paths[9]  = "011";     targ[9]  = S_SELIR;
    paths[10] = "0110";    targ[10] = S_CAPIR;
    paths[11] = "01100";   targ[11] = S_SHIR;
    paths[12] = "01101";   targ[12] = S_EX1IR;
    paths[13] = "011010";  targ[13] = S_PAUSEIR;
    paths[14] = "0110101"; targ[14] = S_EX2IR;
    paths[15] = "011011";  targ[15] = S_UPDIR;

    bus_if.TMS = 1'b0;

    // Reset, then pin the post-reset output values.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    to_low_half();
    check("rst_state", bus_if.TapState, 4'hF);
    check("rst_tlr", bus_if.TestLogicReset, 1);
    check("rst_capdr", bus_if.CaptureDR, 0);
    check("rst_shdr", bus_if.ShiftDR, 0);
    check("rst_shir", bus_if.ShiftIR, 0);
    check("rst_select", bus_if.Select, 0);
    check("rst_enable", bus_if.Enable, 0);
    check("rst_clocks", {bus_if.ClockDR, bus_if.ClockIR, bus_if.UpdateDR, bus_if.UpdateIR}, 4'hF);

    // Every state, then five TMS=1 back to TLR.
    for (int i = 0; i < 16; i++) begin
      for (int j = 0; j < paths[i].len(); j++) step(paths[i][j] == "1", 1'b0);
      check("walk_state", bus_if.TapState, targ[i]);
      tms_ones(5);
      check("tms5_state", bus_if.TapState, 4'hF);
      check("tms5_tlr", bus_if.TestLogicReset, 1);
    end

    // Capture then shift 8'hA5 through the bypass register.
    step(1'b0, 1'b0);
    check("p2_rti", bus_if.TapState, 4'hC);
    step(1'b1, 1'b0);
    check("p2_seldr", bus_if.TapState, 4'h7);
    base_dr = n_clkdr;
    step(1'b0, 1'b0);
    check("p2_capdr", bus_if.TapState, 4'h6);
    check("p2_capture_hi", bus_if.CaptureDR, 1);
    check("p2_no_clkdr_yet", n_clkdr - base_dr, 0);
    step(1'b0, 1'b0);
    check("p2_shdr", bus_if.TapState, 4'h2);
    check("p2_capture_lo", bus_if.CaptureDR, 0);
    check("p2_shift_hi", bus_if.ShiftDR, 1);
    check("p2_first_clkdr", n_clkdr - base_dr, 1);

    pat = 8'hA5;
    exp_q.push_back(1'b0);
    for (int k = 0; k < 8; k++) exp_q.push_back(pat[k]);
    for (int k = 0; k < 9; k++) begin
      tdi = (k < 8) ? pat[k] : 1'b0;
      to_low_half();
      check("bypass_tdo", tdo, exp_q.pop_front());
      check("bypass_enable", bus_if.Enable, 1);
      step(k == 8, 1'b0);
    end
    check("p3_ex1dr", bus_if.TapState, 4'h1);
    tdi = 1'b0;
    tms_ones(5);

    // IR walk: Select across the IR column, clock and update pulse counts.
    step(1'b0, 1'b0);
    walk_states = '{4'h7, 4'h4, 4'hE, 4'hA, 4'h9, 4'hD, 4'hC};
    walk_sel    = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    base_dr = n_clkdr; base_ir = n_clkir; base_uir = n_updir;
    for (int k = 0; k < 7; k++) begin
      step((k == 0) || (k == 1) || (k == 4) || (k == 5), 1'b0);
      check("ir_walk_state", bus_if.TapState, walk_states[k]);
      to_low_half();
      check("ir_walk_select", bus_if.Select, walk_sel[k]);
    end
    check("ir_clock_pulses", n_clkir - base_ir, 2);
    check("ir_update_pulses", n_updir - base_uir, 1);
    check("ir_no_clkdr", n_clkdr - base_dr, 0);

    // Capture, exit, pause, exit, update: one ClockDR and one UpdateDR.
    tms_ones(5);
    base_dr = n_clkdr; base_udr = n_upddr;
    step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b0, 1'b0);
    check("p6_capdr", bus_if.TapState, 4'h6);
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b1, 1'b0); step(1'b1, 1'b0);
    check("p6_upddr", bus_if.TapState, 4'h5);
    check("p6_clkdr_once", n_clkdr - base_dr, 1);
    step(1'b0, 1'b0);
    check("p6_rti", bus_if.TapState, 4'hC);
    check("p6_upddr_once", n_upddr - base_udr, 1);
    check("p6_clkdr_still_once", n_clkdr - base_dr, 1);

    // Reset in the middle of a shift.
    step(1'b1, 1'b0); step(1'b0, 1'b0); step(1'b0, 1'b0);
    check("p5_shdr", bus_if.TapState, 4'h2);
    step(1'b0, 1'b1);
    check("p5_rst_state", bus_if.TapState, 4'hF);
    check("p5_rst_shift", bus_if.ShiftDR, 0);
    base_dr = n_clkdr;
    tms_ones(3);
    check("p5_no_clkdr", n_clkdr - base_dr, 0);

    // Randomized TMS with occasional reset; the compare process checks.
    for (int i = 0; i < 1500; i++) begin
      tdi = 1'($urandom_range(0, 1));
      step(1'($urandom_range(0, 1)), $urandom_range(0, 63) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tap_controller.md
Name: tap_controller

Overview:
- IEEE 1149.1 TAP state machine for the ripple-adder DFT JTAG chain.
- Sits directly upstream of the bypass, instruction and boundary-scan registers.
- Decodes TMS into the 16 TAP states and drives their shift/capture/update controls, including the ShiftDR/ClockDR pair that the bypass register consumes.
- TCK is the only clock. TCK is also the source of every gated data-register and instruction-register clock.

Parameters:
- STATE_W, 4, width of the encoded TAP state. Fixed at 4. Exposed for the package typedef only.

Ports:
- TCK  input  1  test clock. The only clock. Sequential logic uses its rising edge, and its falling edge where stated below.
- Reset  input  1  synchronous, active-high. Sampled on rising TCK. Forces Test-Logic-Reset.
- TMS  input  1  test mode select. Sampled on rising TCK.
- TapState  output  4  current state encoding, for debug and the bench.
- TestLogicReset  output  1  high while in Test-Logic-Reset.
- CaptureDR  output  1  high in Capture-DR.
- ShiftDR  output  1  high in Shift-DR.
- ClockDR  output  1  gated TCK for data registers.
- UpdateDR  output  1  gated TCK, rising edge on the update of the selected data register.
- ShiftIR  output  1  high in Shift-IR.
- ClockIR  output  1  gated TCK for the instruction register.
- UpdateIR  output  1  gated TCK for the instruction update.
- Select  output  1  1 = IR path, 0 = DR path, for the TDO mux.
- Enable  output  1  TDO output enable.

Behaviour:
- **Interface timing (already decided):** one clock, TCK. Reset is synchronous and active-high, sampled on rising TCK.
- **States:** TLR, RTI, SelDR, CapDR, ShDR, Ex1DR, PauseDR, Ex2DR, UpdDR, SelIR, CapIR, ShIR, Ex1IR, PauseIR, Ex2IR, UpdIR.
- **Transitions on rising TCK (TMS=0 / TMS=1):**
  - TLR → RTI / TLR
  - RTI → RTI / SelDR
  - SelDR → CapDR / SelIR
  - CapDR → ShDR / Ex1DR
  - ShDR → ShDR / Ex1DR
  - Ex1DR → PauseDR / UpdDR
  - PauseDR → PauseDR / Ex2DR
  - Ex2DR → ShDR / UpdDR
  - UpdDR → RTI / SelDR
  - SelIR → CapIR / TLR
  - IR column mirrors the DR column.
- **Reset:**
  - Reset=1 at a rising TCK puts the state in TLR, overriding TMS, including mid-shift.
  - Falling-edge registers clear on the next falling TCK while in TLR.
  - After reset, outputs are:
    - TestLogicReset = 1
    - all shift/capture outputs = 0
    - Select = 0, Enable = 0
    - ClockDR, ClockIR, UpdateDR, UpdateIR = 1 (idle high)
- **Recovery:** five consecutive TMS=1 from any state reach TLR.
- **Moore decodes:** TestLogicReset, CaptureDR, ShiftDR and ShiftIR decode combinationally from the state. They are valid before the next rising TCK.
  - Consequence: the bypass register's D = TDI & ShiftDR is 0 during Capture-DR (captures 0) and TDI during Shift-DR.
- **Falling-edge enables:** registered on falling TCK from the current state.
  - DrClkEn = state ∈ {CapDR, ShDR}
  - IrClkEn = state ∈ {CapIR, ShIR}
  - DrUpdEn = (state == UpdDR)
  - IrUpdEn = (state == UpdIR)
  - Enable = state ∈ {ShDR, ShIR}
  - Select = state is in the IR column (SelIR through UpdIR)
- **Gated clocks:**
  - ClockDR = TCK | ~DrClkEn. ClockIR = TCK | ~IrClkEn.
  - ClockDR therefore rises exactly at the rising TCK that leaves CapDR or ShDR, once per capture or shift cycle.
  - UpdateDR and UpdateIR are low during the falling TCK half-cycle spent in UpdDR / UpdIR.
  - The IR pair follows the same rules.
  - Each gate is one instantiated OR cell. No other logic sits in the clock path.
- **Simultaneous events:**
  - Reset wins over TMS.
  - A single cycle in Ex1DR followed by UpdDR produces no ClockDR pulse.
  - Pause states hold all clocks high.

Decomposition:
- **Package tap_pkg:**
  - tap_state_t enum holding all 16 states.
  - Encodings follow the 1149.1 hex table, e.g. TLR=4'hF, RTI=4'hC, ShDR=4'h2, ShIR=4'hA.
  - Helper functions is_ir_column() and next_state(state, tms).
- **Sub-module tap_clock_gate:**
  - Falling-edge enable flop plus OR cell.
  - Instantiated four times: ClockDR, ClockIR, UpdateDR, UpdateIR.

Test Plan:
1. From any state (each visited in turn), hold TMS=1 for 5 TCKs → TapState=4'hF and TestLogicReset=1, with at most 5 cycles.
2. From TLR, apply TMS 0,1,0,0 → RTI, SelDR, CapDR, ShDR. Check:
   - CaptureDR=1 for exactly 1 cycle.
   - ShiftDR=1 from the 4th rising edge onward.
   - First ClockDR rising edge coincides with the rising TCK that leaves CapDR.
3. Chain with the bypass register and hold ShDR for 8 TCKs with TDI = 8'hA5, LSB first → TDO shows a first bit 0 (captured), then 1,0,1,0,0,1,0,1 lagging TDI by one cycle. Enable=1 throughout.
4. Walk the IR path with TMS 1,1,0,0,1,1,0 → Select=1 from SelIR through UpdIR. Check:
   - 1 ClockIR pulse each for CapIR and ShIR.
   - Exactly 1 UpdateIR rising edge.
   - End state RTI with Select=0.
5. In ShDR, assert Reset for one TCK → TapState=TLR next cycle, ShiftDR=0, and no further ClockDR edges.
6. With TMS 0,1,0,1,0,1,1 (CapDR→Ex1DR→PauseDR→Ex2DR→UpdDR), check:
   - ClockDR rises once (leaving CapDR).
   - ClockDR stays high through Ex1DR, PauseDR and Ex2DR.
   - UpdateDR rises once.
